// File: rtl/uart_pkg.sv
// Shared UART constants: bit timing at 50 MHz / 115200 baud and receiver state encoding.
package uart_pkg;

  localparam int CLKS_PER_BIT = 434;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2 - 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte handshake: receiver is master (drives byte, valid, flags), consumer is slave.
interface uart_rx_if;
  import uart_pkg::*;

  byte_t rx_data;
  logic  rx_valid;
  logic  rx_ready;
  logic  frame_err;
  logic  overrun;

  modport master (output rx_data, output rx_valid, output frame_err, output overrun,
                  input  rx_ready);
  modport slave  (input  rx_data, input  rx_valid, input  frame_err, input  overrun,
                  output rx_ready);

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous rx line; resets to the idle (high) level.
module uart_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, byte held until accepted, one-cycle frame_err/overrun pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int HALF_BIT     = uart_pkg::HALF_BIT
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master bus
);
  import uart_pkg::*;

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT);

  logic          rx_sync;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [2:0]    idx_q,   idx_d;
  byte_t         shift_q, shift_d;
  logic          done_q,  done_d;
  logic          stop_q,  stop_d;
  byte_t         data_q,  data_d;
  logic          valid_q, valid_d;
  logic          ferr_q,  ferr_d;
  logic          ovr_q,   ovr_d;
  logic          good;

  uart_sync u_sync (.clk(clk), .rst(rst), .d_i(rx), .q_o(rx_sync));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    stop_d  = stop_q;
    case (state_q)
      ST_IDLE: begin
        if (!rx_sync) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = rx_sync ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_sync;
          if (idx_q == 3'd7) state_d = ST_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        // Stop sample is registered first, then resolved one cycle later on the way back to IDLE.
        if (done_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          done_d = 1'b1;
          stop_d = rx_sync;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    good    = done_q && stop_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = done_q && !stop_q;
    ovr_d   = good && valid_q && !bus.rx_ready;
    if (good && (!valid_q || bus.rx_ready)) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end else if (valid_q && bus.rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      done_q  <= 1'b0;
      stop_q  <= 1'b0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bench-side transmitter drives rx, monitor counts output events.
module tb_uart_rx;

  localparam int C = 434;
  localparam int H = 216;
  localparam int LAT = 2 + H + 9 * C + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(C), .HALF_BIT(H)) dut (
    .clk(clk), .rst(rst), .rx(rx), .bus(bus)
  );

  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int         vrise     = 0;
  int         vfall     = 0;
  int         vrise_cyc = 0;
  int         ferr_n    = 0;
  int         ovr_n     = 0;
  logic [7:0] last_data = 8'h00;
  logic       vprev     = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rx_valid && !vprev) begin
      vrise     <= vrise + 1;
      vrise_cyc <= cyc;
      last_data <= bus.rx_data;
    end
    if (!bus.rx_valid && vprev) vfall <= vfall + 1;
    vprev  <= bus.rx_valid;
    ferr_n <= ferr_n + int'(bus.frame_err);
    ovr_n  <= ovr_n + int'(bus.overrun);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full 8N1 frame; stop_low holds the stop bit low only through its mid-point.
  task automatic send(input logic [7:0] d, input bit stop_low);
    rx = 1'b0;
    wait_neg(C);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_neg(C);
    end
    if (stop_low) begin
      rx = 1'b0;
      wait_neg(H + 30);
      rx = 1'b1;
      wait_neg(C - H - 30);
    end else begin
      rx = 1'b1;
      wait_neg(C);
    end
  endtask

  initial begin
    int k, k2, v0, f0, o0, fall0;
    bus.rx_ready = 1'b0;

    wait_neg(3);
    check("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    check("rst_rx_data", {24'd0, bus.rx_data}, 32'h00);
    check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
    check("rst_overrun", {31'd0, bus.overrun}, 32'd0);
    rst = 1'b0;
    wait_neg(5);

    // Single byte with consumer always ready.
    bus.rx_ready = 1'b1;
    v0 = vrise; f0 = ferr_n; o0 = ovr_n;
    k = cyc;
    send(8'hA5, 1'b0);
    wait_neg(4);
    check("a5_valid_pulses", vrise - v0, 1);
    check("a5_data", {24'd0, last_data}, 32'hA5);
    check("a5_frame_err", ferr_n - f0, 0);
    check("a5_overrun", ovr_n - o0, 0);
    check("a5_latency_window",
          {31'd0, ((vrise_cyc - k) >= LAT - 1) && ((vrise_cyc - k) <= LAT + 1)}, 32'd1);
    check("a5_valid_cleared", {31'd0, bus.rx_valid}, 32'd0);
    check("a5_data_retained", {24'd0, bus.rx_data}, 32'hA5);

    // Short low glitch shorter than half a bit.
    v0 = vrise; f0 = ferr_n; o0 = ovr_n;
    rx = 1'b0;
    wait_neg(100);
    rx = 1'b1;
    wait_neg(2 * C);
    check("glitch_valid", vrise - v0, 0);
    check("glitch_frame_err", ferr_n - f0, 0);
    check("glitch_overrun", ovr_n - o0, 0);

    // Bad stop bit.
    v0 = vrise; f0 = ferr_n; o0 = ovr_n;
    send(8'h3C, 1'b1);
    wait_neg(2 * C);
    check("ferr_pulse_cycles", ferr_n - f0, 1);
    check("ferr_no_valid", vrise - v0, 0);
    check("ferr_data_kept", {24'd0, bus.rx_data}, 32'hA5);
    check("ferr_overrun", ovr_n - o0, 0);

    // Back-to-back with consumer stalled: second byte overruns.
    bus.rx_ready = 1'b0;
    v0 = vrise; f0 = ferr_n; o0 = ovr_n;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    wait_neg(4);
    check("ovr_valid_rises", vrise - v0, 1);
    check("ovr_valid_high", {31'd0, bus.rx_valid}, 32'd1);
    check("ovr_data_held", {24'd0, bus.rx_data}, 32'h11);
    check("ovr_pulse_cycles", ovr_n - o0, 1);
    check("ovr_frame_err", ferr_n - f0, 0);
    bus.rx_ready = 1'b1;
    wait_neg(1);
    check("ovr_accept_clears", {31'd0, bus.rx_valid}, 32'd0);

    // Ready rises exactly on the completion cycle of the second byte.
    bus.rx_ready = 1'b0;
    wait_neg(2);
    o0 = ovr_n;
    send(8'h11, 1'b0);
    check("sim_first_held", {24'd0, bus.rx_data}, 32'h11);
    fall0 = vfall;
    k2 = cyc;
    fork
      send(8'h22, 1'b0);
      begin
        while (cyc < k2 + LAT - 1) @(negedge clk);
        bus.rx_ready = 1'b1;
        wait_neg(1);
        check("sim_valid_stays", {31'd0, bus.rx_valid}, 32'd1);
        check("sim_new_data", {24'd0, bus.rx_data}, 32'h22);
        wait_neg(1);
        check("sim_next_accept_clears", {31'd0, bus.rx_valid}, 32'd0);
      end
    join
    wait_neg(2);
    check("sim_no_overrun", ovr_n - o0, 0);
    check("sim_single_fall", vfall - fall0, 1);

    // Reset in the middle of d4, then a clean frame.
    rx = 1'b0;
    wait_neg(C);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      wait_neg(C);
    end
    rx = 1'b0;
    wait_neg(H);
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    check("mid_rst_async_data", {24'd0, bus.rx_data}, 32'h00);
    check("mid_rst_async_valid", {31'd0, bus.rx_valid}, 32'd0);
    wait_neg(20);
    rst = 1'b0;
    v0 = vrise; f0 = ferr_n; o0 = ovr_n;
    wait_neg(2 * C);
    check("post_rst_quiet", vrise - v0, 0);
    send(8'h5A, 1'b0);
    wait_neg(4);
    check("post_rst_valid", vrise - v0, 1);
    check("post_rst_data", {24'd0, last_data}, 32'h5A);
    check("post_rst_frame_err", ferr_n - f0, 0);
    check("post_rst_overrun", ovr_n - o0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
